// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_pkg;

  // Sequencer FSM states. The encoding is visible on state_out for debug.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    WAIT_MEM = 3'd2,
    FLUSH    = 3'd3,
    ERROR    = 3'd4
  } seq_state_t;

  // Bit positions of the per-stage enables in req_out.
  localparam int STG_FETCH  = 0;
  localparam int STG_DECODE = 1;
  localparam int STG_EXEC   = 2;
  localparam int STG_WB     = 3;

  // Stage-enable patterns driven onto req_out.
  localparam logic [3:0] REQ_ALL   = 4'b1111;
  localparam logic [3:0] REQ_STALL = 4'b1100;
  localparam logic [3:0] REQ_FLUSH = 4'b0001;
  localparam logic [3:0] REQ_NONE  = 4'b0000;

endpackage

// File: rtl/pipe_sequencer_hazard_detect.sv
// Decode-vs-execute read-after-write hazard compare. Purely combinational.
module hazard_detect (
  input  logic [4:0] rs1_i,
  input  logic       rs1_read_i,
  input  logic [4:0] rs2_i,
  input  logic       rs2_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_rd_write_i,
  output logic       hazard_o
);

  logic [1:0] src_hit;
  logic [4:0] src_reg  [2];
  logic [1:0] src_read;

  assign src_reg[0]  = rs1_i;
  assign src_reg[1]  = rs2_i;
  assign src_read[0] = rs1_read_i;
  assign src_read[1] = rs2_read_i;

  // A source hazards only if it is actually read, is not x0, and matches
  // the register execute is about to write.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_read[gi] && (src_reg[gi] != 5'd0) &&
                           ex_rd_write_i && (ex_rd_i == src_reg[gi]);
    end
  endgenerate

  assign hazard_o = |src_hit;

endmodule

// File: rtl/pipe_sequencer.sv
// Central fetch/decode/execute/writeback sequencer: stage enables, fetch
// handshake tracking, RAW bubbles, mispredict flush and fetch-timeout trap.
// All outputs are registered; each cycle's outputs describe the state the
// FSM has just moved into, given the inputs sampled on that edge.
module pipe_sequencer
  import pipe_pkg::*;
#(
  parameter int RESET_HOLD    = 2,
  parameter int FLUSH_CYCLES  = 2,
  parameter int FETCH_TIMEOUT = 15,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_req_in,
  input  logic             gnt_in,
  input  logic             rvalid_in,
  input  logic             branch_mispredicted_in,
  input  logic [4:0]       rs1_unreg_in,
  input  logic             rs1_read_unreg_in,
  input  logic [4:0]       rs2_unreg_in,
  input  logic             rs2_read_unreg_in,
  input  logic [4:0]       ex_rd_in,
  input  logic             ex_rd_write_in,
  output logic [3:0]       req_out,
  output logic             stall_out,
  output logic             flush_out,
  output logic             bus_error_out,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] stall_cnt_out
);

  localparam int HOLD_W  = (RESET_HOLD   > 1) ? $clog2(RESET_HOLD)    : 1;
  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES)  : 1;
  localparam int TO_W    = $clog2(FETCH_TIMEOUT + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(FETCH_TIMEOUT - 1);

  seq_state_t         state_q, state_d;
  logic [3:0]         req_q, req_d;
  logic               stall_q, stall_d;
  logic               flush_q, flush_d;
  logic               bus_error_q, bus_error_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               gnt_seen_q, gnt_seen_d;
  logic               pending_flush_q, pending_flush_d;

  logic hazard;
  logic fetch_incomplete;
  logic gnt_now;
  logic pend_now;

  hazard_detect u_hazard (
    .rs1_i         (rs1_unreg_in),
    .rs1_read_i    (rs1_read_unreg_in),
    .rs2_i         (rs2_unreg_in),
    .rs2_read_i    (rs2_read_unreg_in),
    .ex_rd_i       (ex_rd_in),
    .ex_rd_write_i (ex_rd_write_in),
    .hazard_o      (hazard)
  );

  assign fetch_incomplete = instr_req_in && !(gnt_in && rvalid_in);
  // A grant seen on an earlier cycle or this one keeps the fetch outstanding.
  assign gnt_now  = gnt_seen_q || gnt_in;
  // A mispredict arriving while waiting is remembered until the fetch lands.
  assign pend_now = pending_flush_q || branch_mispredicted_in;

  // Next-state, next-output and counter updates.
  always_comb begin
    state_d         = state_q;
    req_d           = REQ_NONE;
    stall_d         = 1'b0;
    flush_d         = 1'b0;
    bus_error_d     = bus_error_q;
    hold_d          = hold_q;
    flush_cnt_d     = flush_cnt_q;
    to_cnt_d        = to_cnt_q;
    gnt_seen_d      = gnt_seen_q;
    pending_flush_d = pending_flush_q;

    case (state_q)
      IDLE: begin
        // The exit cycle itself is still idle, so exactly RESET_HOLD idle cycles.
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      RUN: begin
        if (branch_mispredicted_in) begin
          state_d         = FLUSH;
          req_d           = REQ_FLUSH;
          flush_d         = 1'b1;
          flush_cnt_d     = '0;
          pending_flush_d = 1'b0;
        end else if (fetch_incomplete) begin
          state_d         = WAIT_MEM;
          req_d           = REQ_STALL;
          stall_d         = 1'b1;
          to_cnt_d        = TO_W'(1);
          gnt_seen_d      = gnt_in;
          pending_flush_d = 1'b0;
        end else if (hazard) begin
          req_d   = REQ_STALL;
          stall_d = 1'b1;
        end else begin
          req_d = REQ_ALL;
        end
      end

      WAIT_MEM: begin
        gnt_seen_d = gnt_now;
        if (rvalid_in && gnt_now) begin
          to_cnt_d   = '0;
          gnt_seen_d = 1'b0;
          if (pend_now) begin
            state_d         = FLUSH;
            req_d           = REQ_FLUSH;
            flush_d         = 1'b1;
            flush_cnt_d     = '0;
            pending_flush_d = 1'b0;
          end else begin
            state_d = RUN;
            req_d   = REQ_ALL;
          end
        end else begin
          pending_flush_d = pend_now;
          if (to_cnt_q == TO_LAST) begin
            state_d     = ERROR;
            bus_error_d = 1'b1;
            to_cnt_d    = '0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
            req_d    = REQ_STALL;
            stall_d  = 1'b1;
          end
        end
      end

      FLUSH: begin
        if (branch_mispredicted_in) begin
          flush_cnt_d = '0;
          req_d       = REQ_FLUSH;
          flush_d     = 1'b1;
        end else if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = RUN;
          req_d       = REQ_ALL;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
          req_d       = REQ_FLUSH;
          flush_d     = 1'b1;
        end
      end

      ERROR: begin
        bus_error_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating count of stalled cycles, counted alongside the stall output.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_d && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      req_q           <= REQ_NONE;
      stall_q         <= 1'b0;
      flush_q         <= 1'b0;
      bus_error_q     <= 1'b0;
      stall_cnt_q     <= '0;
      hold_q          <= '0;
      flush_cnt_q     <= '0;
      to_cnt_q        <= '0;
      gnt_seen_q      <= 1'b0;
      pending_flush_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      stall_q         <= stall_d;
      flush_q         <= flush_d;
      bus_error_q     <= bus_error_d;
      stall_cnt_q     <= stall_cnt_d;
      hold_q          <= hold_d;
      flush_cnt_q     <= flush_cnt_d;
      to_cnt_q        <= to_cnt_d;
      gnt_seen_q      <= gnt_seen_d;
      pending_flush_q <= pending_flush_d;
    end
  end

  assign req_out       = req_q;
  assign stall_out     = stall_q;
  assign flush_out     = flush_q;
  assign bus_error_out = bus_error_q;
  assign state_out     = state_q;
  assign stall_cnt_out = stall_cnt_q;

endmodule

// File: doc/pipe_sequencer.md
Name: pipe_sequencer

Overview:
- Central sequencer for the fetch/decode/execute/writeback pipeline.
- Generates per-stage enables req_out[3:0] and tracks the instruction-memory handshake (req/gnt/rvalid).
- Detects a decode-vs-execute RAW hazard and inserts bubbles.
- Squashes wrong-path instructions on branch mispredict and traps on fetch timeout.

Parameters:
RESET_HOLD, 2, cycles all stages are held idle after reset release (>=1)
FLUSH_CYCLES, 2, cycles flush_out stays asserted after a mispredict (>=1)
FETCH_TIMEOUT, 15, max cycles waiting on gnt/rvalid before a bus error (>=2)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  pipeline clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
instr_req_in  in  1  fetch stage requests an instruction this cycle
gnt_in  in  1  memory accepted the request
rvalid_in  in  1  memory returns instruction data
branch_mispredicted_in  in  1  execute resolved a mispredicted branch
rs1_unreg_in  in  5  decode source register 1 (combinational from decode)
rs1_read_unreg_in  in  1  decode reads rs1
rs2_unreg_in  in  5  decode source register 2
rs2_read_unreg_in  in  1  decode reads rs2
ex_rd_in  in  5  destination register of the instruction in execute
ex_rd_write_in  in  1  execute instruction writes ex_rd_in
req_out  out  4  stage enables: [0] fetch, [1] decode, [2] execute, [3] writeback
stall_out  out  1  decode must emit a bubble (valid_out=0) this cycle
flush_out  out  1  fetch/decode discard their held instruction
bus_error_out  out  1  sticky fetch-timeout error
state_out  out  3  current FSM state encoding (debug)
stall_cnt_out  out  CNT_W  saturating count of cycles with stall_out=1

Behaviour:
- All outputs are registered. Inputs sampled at posedge N determine outputs valid after posedge N.
- Reset (reset==0 at posedge) is asserted in any state and aborts any outstanding fetch. Reset values: state=IDLE, req_out=0, stall_out=0, flush_out=0, bus_error_out=0, stall_cnt_out=0, hold/flush/timeout counters=0, pending_flush=0.
- IDLE: req_out=4'b0000. The hold counter increments each cycle; when it reaches RESET_HOLD-1 the FSM goes to RUN.
- RUN: default req_out=4'b1111, stall_out=0. Per-cycle priority, highest first:
  - branch_mispredicted_in=1: go to FLUSH. The hazard is ignored because the instruction is squashed.
  - Fetch handshake incomplete, i.e. instr_req_in=1 and !(gnt_in and rvalid_in): go to WAIT_MEM. req_out=4'b1100, stall_out=1.
  - Hazard: stay in RUN with req_out=4'b1100 and stall_out=1 for exactly that cycle. The hazard condition is:
    - (rs1_read_unreg_in and rs1_unreg_in!=0 and ex_rd_write_in and ex_rd_in==rs1_unreg_in), or
    - the same condition on rs2.
    - x0 never hazards.
  - Otherwise: req_out=4'b1111.
  - gnt_in and rvalid_in in the same cycle is a zero-wait fetch and stays in RUN.
- WAIT_MEM: req_out=4'b1100, stall_out=1.
  - The timeout counter starts at 1 on entry and increments each cycle.
  - Once gnt_in is seen, the outstanding flag is set and later gnt_in is ignored.
  - On rvalid_in with grant seen (the same cycle counts): go to RUN, or to FLUSH if pending_flush=1. Clear the counter.
  - branch_mispredicted_in in WAIT_MEM sets pending_flush. The outstanding transaction is never abandoned.
  - If the counter reaches FETCH_TIMEOUT with no rvalid_in: go to ERROR.
- FLUSH: req_out=4'b0001, flush_out=1 for FLUSH_CYCLES cycles, then RUN.
  - A new mispredict in FLUSH restarts the flush counter.
  - Hazards are not evaluated in FLUSH.
  - pending_flush clears on entry.
- ERROR: req_out=0, bus_error_out=1. ERROR exits only via reset.
- stall_cnt_out increments every cycle stall_out=1 and saturates at 2^CNT_W-1 (no wrap).
- State encoding: IDLE=0, RUN=1, WAIT_MEM=2, FLUSH=3, ERROR=4.

Decomposition:
- Shared package pipe_pkg holds:
  - enum seq_state_t (IDLE, RUN, WAIT_MEM, FLUSH, ERROR)
  - stage index constants STG_FETCH=0, STG_DECODE=1, STG_EXEC=2, STG_WB=3
  - req patterns REQ_ALL=4'b1111, REQ_STALL=4'b1100, REQ_FLUSH=4'b0001, REQ_NONE=4'b0000
- Sub-module hazard_detect: combinational compare of rs1/rs2 against ex_rd, producing the hazard flag. The FSM, counters and handshake tracking stay in pipe_sequencer.

Test Plan:
- Release reset (reset 0->1), instr_req_in=gnt_in=rvalid_in=1 constant -> req_out=0 for 2 cycles, then 4'b1111 every cycle; stall_cnt_out stays 0.
- RUN; rs1_unreg_in=5, rs1_read_unreg_in=1, ex_rd_in=5, ex_rd_write_in=1 for one cycle -> one cycle of req_out=4'b1100, stall_out=1, stall_cnt_out=1. Repeat with registers =0 -> no stall.
- RUN; gnt_in=1, rvalid_in=0 for 3 cycles, then rvalid_in=1 -> state WAIT_MEM (2) with req_out=4'b1100 for 3 cycles, then RUN with 4'b1111.
- In WAIT_MEM assert branch_mispredicted_in for one cycle, rvalid two cycles later -> FLUSH entered after rvalid; flush_out=1 and req_out=4'b0001 for 2 cycles, then RUN.
- gnt_in=0 held for 15 cycles -> ERROR: bus_error_out=1, req_out=0, held until reset; reset low for one cycle clears everything to IDLE.
- stall_cnt_out forced near saturation via CNT_W=4 and 20 stall cycles -> stall_cnt_out holds at 15.
